// File: rtl/uart_transmitter_if.sv
// Byte handshake and line/status bundle for uart_transmitter.
// The slave modport is the transmitter side; the master modport is the byte producer.
interface uart_transmitter_if;
  logic [7:0] i_tx_data;
  logic       i_tx_data_valid;
  logic       o_tx_data_ready;
  logic       o_tx;
  logic       o_busy;

  modport master (
    output i_tx_data,
    output i_tx_data_valid,
    input  o_tx_data_ready,
    input  o_tx,
    input  o_busy
  );

  modport slave (
    input  i_tx_data,
    input  i_tx_data_valid,
    output o_tx_data_ready,
    output o_tx,
    output o_busy
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO; frames are sent back-to-back while data is buffered.
// Define UART_TRANSMITTER_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a buffered byte
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (only with UART_TRANSMITTER_PARITY_EN)
// STOP   | stop bit (high); chains straight into START when the FIFO has data
module uart_transmitter #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  uart_transmitter_if.slave bus
);

  localparam int BIT_CYCLES = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LOAD = CW'(BIT_CYCLES - 1);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TRANSMITTER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          load;
  logic          fifo_full;
  logic          fifo_nonempty;
  logic [7:0]    head;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          cnt_done;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          tx_q;
  logic          tx_next;
`ifdef UART_TRANSMITTER_PARITY_EN
  logic          parity_q;
  logic          parity_next;
`endif

  assign fifo_full     = (count == FULL_COUNT);
  assign fifo_nonempty = (count != '0);
  // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
  assign push          = bus.i_tx_data_valid && !fifo_full;
  assign head          = mem[rd_ptr];
  assign cnt_done      = (cnt == '0);

  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.i_tx_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, load})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TRANSMITTER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      tx_q    <= tx_next;
`ifdef UART_TRANSMITTER_PARITY_EN
      parity_q <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx_q;
    load       = 1'b0;
`ifdef UART_TRANSMITTER_PARITY_EN
    parity_next = parity_q;
`endif
    case (state)
      IDLE: begin
        tx_next  = 1'b1;
        cnt_next = '0;
        bit_next = '0;
        if (fifo_nonempty) begin
          load       = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
          cnt_next   = BIT_LOAD;
        end
      end
      START: begin
        if (cnt_done) begin
          state_next = DATA;
          bit_next   = '0;
          cnt_next   = BIT_LOAD;
          tx_next    = shift[0];
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      DATA: begin
        if (cnt_done) begin
          cnt_next = BIT_LOAD;
          if (bit_idx == 3'd7) begin
`ifdef UART_TRANSMITTER_PARITY_EN
            state_next = PARITY;
            tx_next    = parity_q;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift[7:1]};
            tx_next    = shift[1];
          end
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
`ifdef UART_TRANSMITTER_PARITY_EN
      PARITY: begin
        if (cnt_done) begin
          state_next = STOP;
          cnt_next   = BIT_LOAD;
          tx_next    = 1'b1;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_done) begin
          bit_next = '0;
          if (fifo_nonempty) begin
            load       = 1'b1;
            state_next = START;
            tx_next    = 1'b0;
            cnt_next   = BIT_LOAD;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        cnt_next   = '0;
        bit_next   = '0;
      end
    endcase
    if (load) begin
      shift_next = head;
`ifdef UART_TRANSMITTER_PARITY_EN
      parity_next = ^head;
`endif
    end
  end

  assign bus.o_tx            = tx_q;
  assign bus.o_tx_data_ready = !fifo_full;
  assign bus.o_busy          = fifo_nonempty || (state != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: table of single frames, directed multi-cycle sequences and random traffic,
// all compared cycle by cycle against a queue-based timeline model of the line.
`timescale 1ns/1ps
module tb_uart_transmitter;
  localparam int CLK_HZ = 750;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int BC     = 7;   // 750 / 100, truncated
`ifdef UART_TRANSMITTER_PARITY_EN
  localparam int FRAME  = 11;
`else
  localparam int FRAME  = 10;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_transmitter_if bus();

  uart_transmitter #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Timeline model: byte queue plus the start edge of the frame currently on the line.
  int          e = 0;
  logic [7:0]  fifo_q[$];
  bit          in_frame = 1'b0;
  logic [7:0]  cur_byte;
  int          cur_start;
  int          cur_end;
  bit          last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
    end
  endtask

  function automatic logic model_tx();
    int k;
    if (!in_frame) return 1'b1;
    k = (e - cur_start) / BC;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur_byte[k-1];
`ifdef UART_TRANSMITTER_PARITY_EN
    if (k == 9) return ^cur_byte;
`endif
    return 1'b1;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    bus.i_tx_data_valid = v;
    bus.i_tx_data       = d;
  endtask

  task automatic step();
    logic [2:0] exp3;
    @(posedge clk);
    e++;
    if (rst) begin
      fifo_q.delete();
      in_frame = 1'b0;
      last_acc = 1'b0;
    end else begin
      last_acc = bus.i_tx_data_valid && (fifo_q.size() < DEPTH);
      if (in_frame && e >= cur_end) in_frame = 1'b0;
      if (!in_frame && fifo_q.size() > 0) begin
        cur_byte  = fifo_q.pop_front();
        cur_start = e;
        cur_end   = e + FRAME * BC;
        in_frame  = 1'b1;
      end
      if (last_acc) fifo_q.push_back(bus.i_tx_data);
    end
    #1;
    exp3 = {model_tx(), (fifo_q.size() != 0) || in_frame, fifo_q.size() < DEPTH};
    check("cycle{tx,busy,ready}", {29'd0, bus.o_tx, bus.o_busy, bus.o_tx_data_ready}, {29'd0, exp3});
  endtask

  task automatic drain();
    int bound;
    bound = 0;
    while ((in_frame || fifo_q.size() != 0) && bound < 2000) begin
      step();
      bound++;
    end
    if (bound >= 2000) check("drain_timeout", 32'd1, 32'd0);
    repeat (3) step();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       parity;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] frame_bits;
    int          accepted;
    int          bound;
    bit          saw_not_ready;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'hA5, 1'b0};
    vecs[4] = '{8'h07, 1'b1};
    vecs[5] = '{8'h03, 1'b0};
    vecs[6] = '{8'hC3, 1'b0};

    rst = 1'b1;
    drive(1'b0, 8'h00);
    #7;
    check("reset_tx", {31'd0, bus.o_tx}, 32'd1);
    check("reset_busy", {31'd0, bus.o_busy}, 32'd0);
    check("reset_ready", {31'd0, bus.o_tx_data_ready}, 32'd1);
    step();
    #3 rst = 1'b0;
    repeat (3) step();

    // Single frames from the table, sampled at both ends of every bit period.
    for (int i = 0; i < 7; i++) begin
`ifdef UART_TRANSMITTER_PARITY_EN
      frame_bits = {1'b1, vecs[i].parity, vecs[i].data, 1'b0};
`else
      frame_bits = {2'b11, vecs[i].data, 1'b0};
`endif
      drive(1'b1, vecs[i].data);
      step();
      drive(1'b0, 8'h00);
      for (int c = 0; c < FRAME * BC; c++) begin
        step();
        if (c % BC == 0 || c % BC == BC - 1)
          check("frame_bit", {31'd0, bus.o_tx}, {31'd0, frame_bits[c / BC]});
      end
      check("busy_last", {31'd0, bus.o_busy}, 32'd1);
      step();
      check("busy_end", {31'd0, bus.o_busy}, 32'd0);
      check("line_idle", {31'd0, bus.o_tx}, 32'd1);
      repeat (2) step();
    end

    // Back-to-back frames: edge offsets c are counted from the accept edge of the first byte.
    drive(1'b1, 8'h00); step();
    drive(1'b1, 8'hFF); step();
    drive(1'b1, 8'hA5); step();
    drive(1'b0, 8'h00);
    for (int c = 3; c <= 3 * FRAME * BC + 3; c++) begin
      step();
      if (c == FRAME * BC || c == 2 * FRAME * BC)
        check("b2b_stop", {31'd0, bus.o_tx}, 32'd1);
      if (c == 1 + FRAME * BC || c == 1 + 2 * FRAME * BC)
        check("b2b_start", {31'd0, bus.o_tx}, 32'd0);
      if (c == 3 * FRAME * BC)
        check("b2b_busy", {31'd0, bus.o_busy}, 32'd1);
      if (c == 1 + 3 * FRAME * BC)
        check("b2b_done", {31'd0, bus.o_busy}, 32'd0);
    end

    // Valid held high with 0x3C until six bytes are taken.
    accepted = 0;
    bound = 0;
    saw_not_ready = 1'b0;
    drive(1'b1, 8'h3C);
    while (accepted < 6 && bound < 2000) begin
      step();
      if (last_acc) accepted++;
      if (!bus.o_tx_data_ready) saw_not_ready = 1'b1;
      bound++;
    end
    drive(1'b0, 8'h00);
    check("fill_accepted", accepted, 32'd6);
    check("fill_ready_dropped", {31'd0, saw_not_ready}, 32'd1);
    drain();

    // Full FIFO: the extra byte must be dropped and the order kept.
    drive(1'b1, 8'h11); step();
    drive(1'b1, 8'h22); step();
    drive(1'b1, 8'h33); step();
    drive(1'b1, 8'h44); step();
    drive(1'b1, 8'h55); step();
    check("full_ready_low", {31'd0, bus.o_tx_data_ready}, 32'd0);
    drive(1'b1, 8'hEE); step();
    drive(1'b0, 8'h00);
    check("full_still_low", {31'd0, bus.o_tx_data_ready}, 32'd0);
    drain();

    // Reset in data bit 4 of 0xC3 with two more bytes buffered.
    drive(1'b1, 8'hC3); step();
    drive(1'b1, 8'h81); step();
    drive(1'b1, 8'h18); step();
    drive(1'b0, 8'h00);
    for (int c = 3; c <= 1 + 5 * BC + 3; c++) step();
    check("pre_reset_bit4", {31'd0, bus.o_tx}, 32'd0);
    #3 rst = 1'b1;
    #1;
    check("async_tx", {31'd0, bus.o_tx}, 32'd1);
    check("async_busy", {31'd0, bus.o_busy}, 32'd0);
    check("async_ready", {31'd0, bus.o_tx_data_ready}, 32'd1);
    repeat (3) step();
    #3 rst = 1'b0;
    repeat (40) step();
    check("post_reset_idle", {31'd0, bus.o_busy}, 32'd0);
    drive(1'b1, 8'h5A); step();
    drive(1'b0, 8'h00);
    step();
    check("post_reset_start", {31'd0, bus.o_tx}, 32'd0);
    drain();

    // Random traffic: dense first (FIFO mostly full), then sparse with idle gaps.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, (i < 750) ? 3 : 120) == 0), 8'($urandom));
      step();
    end
    drive(1'b0, 8'h00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit byte buffer entries; power of two, minimum 2.
REQ-004 SHALL have port i_clock, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port i_reset, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port i_tx_data, input, 8, byte to transmit.
REQ-007 SHALL have port i_tx_data_valid, input, 1, i_tx_data is valid.
REQ-008 SHALL have port o_tx_data_ready, output, 1, a byte can be accepted this cycle.
REQ-009 SHALL have port o_tx, output, 1, serial line; idle high.
REQ-010 SHALL have port o_busy, output, 1, FIFO non-empty or frame in progress.

Function
REQ-011 SHALL define BIT_CYCLES = CLOCK_FREQUENCY / BAUD_RATE (integer division; 868 at defaults), with every line bit held for exactly BIT_CYCLES clocks.
REQ-012 SHALL accept a byte into the FIFO on a rising edge where i_tx_data_valid and o_tx_data_ready are both 1; i_tx_data is ignored otherwise.
REQ-013 SHALL drive o_tx_data_ready = 1 when FIFO occupancy < FIFO_DEPTH and 0 when full, from registered occupancy only (no same-cycle pop bypass).
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY per REQ-025).
REQ-015 IDLE: o_tx = 1; if FIFO non-empty, pop head into shift register, go to START, o_tx = 0 from that edge.
REQ-016 A byte accepted at edge N into an empty FIFO with FSM in IDLE SHALL produce the start-bit falling edge on o_tx at edge N+1.
REQ-017 START: after BIT_CYCLES, go to DATA with bit index 0.
REQ-018 DATA: send 8 bits LSB first, each BIT_CYCLES; after bit 7 go to STOP.
REQ-019 STOP: o_tx = 1 for BIT_CYCLES; at its end go to START (popping next byte, zero idle gap) if FIFO non-empty, else IDLE.
REQ-020 Push and pop on the same edge SHALL both take effect; occupancy unchanged; FIFO read/write pointers wrap modulo FIFO_DEPTH.
REQ-021 o_busy SHALL be 1 when FIFO occupancy != 0 or state != IDLE, else 0.
REQ-022 o_tx SHALL be driven from a flop (glitch-free).

Reset
REQ-023 Assertion of i_reset SHALL immediately, independent of i_clock, set o_tx = 1, state = IDLE, FIFO empty, bit and cycle counters 0, o_busy = 0, o_tx_data_ready = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame and discard all buffered bytes; after deassertion the line stays idle until a new byte is accepted.

Configuration
REQ-025 With macro UART_TRANSMITTER_PARITY_EN defined, SHALL insert state PARITY between DATA and STOP sending even parity (XOR of the 8 data bits) for BIT_CYCLES; frame = 11 bits.
REQ-026 Without UART_TRANSMITTER_PARITY_EN, no parity state or logic SHALL exist; frame = 10 bits (start, 8 data, 1 stop).

Verification
REQ-027 Single byte 0x55 after reset, defaults -> o_tx low at edge N+1, then bits 1,0,1,0,1,0,1,0, stop high, each 868 cycles; o_busy low after 10*868 cycles.
REQ-028 Bytes 0x00, 0xFF, 0xA5 pushed back-to-back -> three contiguous 8680-cycle frames, no idle high between stop and next start.
REQ-029 Valid held high with 0x3C continuously, FIFO_DEPTH 4 -> ready drops after FIFO fills, reasserts one cycle after each pop; 6 accepted bytes transmitted in order, none lost or duplicated.
REQ-030 Reset pulse 3 cycles in data bit 4 of 0xC3 with 2 bytes buffered -> o_tx high immediately, o_busy 0, ready 1; no further frames until new push.
REQ-031 With UART_TRANSMITTER_PARITY_EN, byte 0x07 -> parity bit 1, byte 0x03 -> parity bit 0; frames 11*868 cycles.
REQ-032 Valid pulsed while full -> byte dropped, FIFO contents and order unchanged.
